network_sequencer: RTL

- Run-control block in front of the three-layer Network.
- Fetches samples from a synchronous sample memory and streams them to the Network input and teacher ports.
- Runs NEPOCH training passes, then one test pass, and forwards test-pass outputs to a result sink.
- Drives the Network mode input; changes mode only when no sample is in flight.

---
 rtl/network_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/network_sequencer.sv
// rtl/network_sequencer.sv - run-control sequencer feeding samples to the Network for NEPOCH training passes and one test pass

module network_sequencer #(
    parameter int NI      = 3,
    parameter int NO      = 2,
    parameter int WF      = 8,
    parameter int WO      = 10,
    parameter int NSAMPLE = 4,
    parameter int NEPOCH  = 2,
    parameter int MAXOUT  = 4,
    localparam int AW     = (NSAMPLE > 1) ? $clog2(NSAMPLE) : 1,
    localparam int EW     = $clog2(NEPOCH + 1),
    localparam int CW     = $clog2(MAXOUT + 1)
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iStart,
    output logic                 oBusy,
    output logic                 oDone,
    output logic                 oMode,
    output logic [AW-1:0]        oAddr_Sample,
    input  logic [NI*WF-1:0]     iData_Sample_Input,
    input  logic [NO*WF-1:0]     iData_Sample_Teacher,
    output logic                 oValid_BM_Input,
    input  logic                 iReady_BM_Input,
    output logic [NI*WF-1:0]     oData_BM_Input,
    output logic                 oValid_BM_Teacher,
    input  logic                 iReady_BM_Teacher,
    output logic [NO*WO-1:0]     oData_BM_Teacher,
    input  logic                 iValid_AM_Output,
    output logic                 oReady_AM_Output,
    input  logic [NO*WO-1:0]     iData_AM_Output,
    output logic                 oValid_BM_Result,
    input  logic                 iReady_BM_Result,
    output logic [NO*WO-1:0]     oData_BM_Result,
    output logic [EW-1:0]        oEpoch
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_mode;
    logic                 r_valid_in;
    logic                 r_valid_tch;
    logic [AW-1:0]        r_addr;
    logic [EW-1:0]        r_epoch;
    logic [CW-1:0]        r_outst;
    logic [CW-1:0]        w_outst_next;
    logic [NI*WF-1:0]     r_data_in;
    logic [NO*WO-1:0]     r_data_tch;
    logic [NO*WO-1:0]     w_tch_ext;

    logic w_hs_in;
    logic w_hs_out;
    logic w_sample_done;
    logic w_last;
    logic w_room;
    logic w_drained;
    logic w_last_epoch;

    assign w_hs_in  = r_valid_in & iReady_BM_Input;
    assign w_hs_out = iValid_AM_Output & oReady_AM_Output;

    // A sample is complete once neither stream still has a pending beat after this cycle.
    assign w_sample_done = (~r_valid_in  | iReady_BM_Input) &
                           (~r_valid_tch | iReady_BM_Teacher);

    assign w_last       = (r_addr == AW'(NSAMPLE - 1));
    assign w_drained    = (r_outst == '0);
    assign w_last_epoch = (r_epoch == EW'(NEPOCH - 1));

    // FETCH never handshakes an input, so room seen here still holds when ISSUE raises valid.
    assign w_room = (w_outst_next < CW'(MAXOUT));

    always_comb begin
        w_outst_next = r_outst;
        if (w_hs_in && !w_hs_out) begin
            w_outst_next = r_outst + 1'b1;
        end else if (w_hs_out && !w_hs_in && (r_outst != '0)) begin
            w_outst_next = r_outst - 1'b1;
        end
    end

    always_comb begin
        w_tch_ext = '0;
        for (int k = 0; k < NO; k++) begin
            w_tch_ext[k*WO +: WO] = WO'(iData_Sample_Teacher[k*WF +: WF]);
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (iStart) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_sample_done) begin
                    if (w_last) begin
                        w_state_next = S_DRAIN;
                    end else if (w_room) begin
                        w_state_next = S_FETCH;
                    end
                end
            end
            S_DRAIN: begin
                if (w_drained) begin
                    w_state_next = r_mode ? S_FETCH : S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mode      <= 1'b1;
            r_addr      <= '0;
            r_epoch     <= '0;
            r_outst     <= '0;
            r_valid_in  <= 1'b0;
            r_valid_tch <= 1'b0;
            r_data_in   <= '0;
            r_data_tch  <= '0;
        end else begin
            r_outst <= w_outst_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_busy  <= 1'b1;
                        r_epoch <= '0;
                        r_mode  <= 1'b1;
                        r_addr  <= '0;
                    end
                end
                S_FETCH: begin
                    r_valid_in  <= 1'b1;
                    r_valid_tch <= r_mode;
                    r_data_in   <= iData_Sample_Input;
                    r_data_tch  <= w_tch_ext;
                end
                S_ISSUE: begin
                    if (w_hs_in) begin
                        r_valid_in <= 1'b0;
                    end
                    if (r_valid_tch && iReady_BM_Teacher) begin
                        r_valid_tch <= 1'b0;
                    end
                    if (w_sample_done && !w_last && w_room) begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_drained) begin
                        if (r_mode) begin
                            r_addr <= '0;
                            if (w_last_epoch) begin
                                r_mode  <= 1'b0;
                                r_epoch <= EW'(NEPOCH);
                            end else begin
                                r_epoch <= r_epoch + 1'b1;
                            end
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_busy <= 1'b0;
                    r_mode <= 1'b1;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    // Training outputs are swallowed here; the test pass forwards them untouched.
    assign oReady_AM_Output = r_mode | iReady_BM_Result;
    assign oValid_BM_Result = ~r_mode & iValid_AM_Output;
    assign oData_BM_Result  = iData_AM_Output;

    assign oBusy             = r_busy;
    assign oDone             = r_done;
    assign oMode             = r_mode;
    assign oAddr_Sample      = r_addr;
    assign oEpoch            = r_epoch;
    assign oValid_BM_Input   = r_valid_in;
    assign oData_BM_Input    = r_data_in;
    assign oValid_BM_Teacher = r_valid_tch;
    assign oData_BM_Teacher  = r_data_tch;

endmodule
